dec_key_prep_256: RTL

DEC_KEY_PREP_256 -- requirements
Module: dec_key_prep_256

---
 rtl/dec_key_prep_256.sv | 103 ++++++++++
 1 files changed

// File: rtl/dec_key_prep_256.sv
// Runs the forward key schedule ROUNDS times on a master key to produce the
// starting key state and delta for the decryption key schedule.
module dec_key_prep_256 #(
    parameter int                    BLOCK_SIZE = 128,
    parameter int                    KEY_SIZE   = 256,
    parameter int                    SIDE_SIZE  = BLOCK_SIZE / 2,
    parameter int                    PD         = 56,
    parameter logic [SIDE_SIZE-1:0]  DELTA0     = 64'h9e3779b97f4a7c15,
    parameter int                    ROUNDS     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [0:KEY_SIZE-1]   key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [0:KEY_SIZE-1]   key_out,
    output logic [0:SIDE_SIZE-1]  delta_out
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [7:0] LAST_CNT = 8'(ROUNDS - 1);

    logic [1:0]            state_r;
    logic [7:0]            cnt_r;
    logic [0:KEY_SIZE-1]   key_r;
    logic [0:SIDE_SIZE-1]  delta_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  valid_r;

    logic [0:SIDE_SIZE-1]  delta_n_s;
    logic [0:KEY_SIZE-1]   k1_s;
    logic [0:KEY_SIZE-1]   key_next_s;

    // One forward step: bump delta, rotate key right by PD, add delta into the low word (carry dropped).
    always_comb begin
        delta_n_s  = delta_r + DELTA0;
        k1_s       = {key_r[KEY_SIZE-PD:KEY_SIZE-1], key_r[0:KEY_SIZE-PD-1]};
        key_next_s = {k1_s[0:KEY_SIZE-SIDE_SIZE-1],
                      k1_s[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1] + delta_n_s};
    end

    // Control FSM and datapath registers; done/out_valid rise one edge after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            key_r   <= '0;
            delta_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        key_r   <= key_in;
                        delta_r <= '0;
                        cnt_r   <= 8'd0;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    key_r   <= key_next_s;
                    delta_r <= delta_n_s;
                    cnt_r   <= cnt_r + 8'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign out_valid = valid_r;
    assign key_out   = key_r;
    assign delta_out = delta_r;

endmodule
